// File: rtl/gpu_mat_seq.sv
// Command sequencer and port arbiter for the GPU matrix register file.
// Expands matrix commands into read/multiply/write column steps and shares the rf ports with the host.
module gpu_mat_seq #(
    parameter int unsigned MAT_COUNT = 4,
    localparam int unsigned MI = $clog2(MAT_COUNT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [MI-1:0] dat_mat_idx,
    input  logic [1:0]    dat_vector_type,
    input  logic [1:0]    dat_vector_idx,
    input  logic [63:0]   dat_in,
    output logic [63:0]   dat_out,
    input  logic          cyc,
    input  logic          we,
    output logic          ack,
    input  logic [15:0]   cmd,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    output logic          busy,
    output logic          cmd_err,
    output logic [MI-1:0] rf_rd_mat_idx,
    output logic [1:0]    rf_rd_vector_type,
    output logic [1:0]    rf_rd_vector_idx,
    input  logic [63:0]   rf_rd_vals,
    output logic          rf_we,
    output logic [MI-1:0] rf_wr_mat_idx,
    output logic [1:0]    rf_wr_vector_type,
    output logic [1:0]    rf_wr_vector_idx,
    output logic [63:0]   rf_wr_vals,
    output logic [MI-1:0] mul_mat_idx,
    output logic [63:0]   mul_in,
    input  logic [63:0]   mul_out
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HOST = 3'd1;
    localparam logic [2:0] S_HACK = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_FILL = 3'd5;

    logic [2:0]    state;
    logic [2:0]    phase;
    logic [1:0]    col;
    logic [MI-1:0] d_q, a_q, b_q;
    logic [1:0]    j_q, k_q;
    logic          is_vec, is_ident;
    logic [63:0]   result;

    logic [3:0] op;
    logic [1:0] fd, fa, fb;
    logic       cmd_illegal;
    logic       cmd_unused;

    assign op = cmd[15:12];
    assign fd = cmd[11:10];
    assign fa = cmd[9:8];
    assign fb = cmd[7:6];
    assign cmd_unused = ^cmd[1:0];

    function automatic logic mat_ok(input logic [1:0] m);
        return 32'(m) < MAT_COUNT;
    endfunction

    always_comb begin
        cmd_illegal = 1'b0;
        case (op)
            4'd0:       cmd_illegal = 1'b0;
            4'd1, 4'd2: cmd_illegal = !mat_ok(fd) || !mat_ok(fa) || !mat_ok(fb) || (fd == fa);
            4'd3, 4'd4: cmd_illegal = !mat_ok(fd);
            default:    cmd_illegal = 1'b1;
        endcase
    end

    // The host access is performed in the IDLE cycle it is seen, so that cycle acts as HOST.
    assign phase     = (state == S_IDLE && cyc) ? S_HOST : state;
    assign cmd_ready = (state == S_IDLE) && !cyc;
    assign busy      = (state == S_RD) || (state == S_WR) || (state == S_FILL);
    assign ack       = (state == S_HACK);
    assign mul_in    = rf_rd_vals;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            col      <= '0;
            d_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            is_vec   <= 1'b0;
            is_ident <= 1'b0;
            result   <= '0;
            dat_out  <= '0;
            cmd_err  <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            case (phase)
                S_HOST: begin
                    state <= S_HACK;
                    if (!we) dat_out <= rf_rd_vals;
                end
                S_HACK: state <= S_IDLE;
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_illegal) begin
                            cmd_err <= 1'b1;
                        end else begin
                            d_q      <= fd[MI-1:0];
                            a_q      <= fa[MI-1:0];
                            b_q      <= fb[MI-1:0];
                            j_q      <= cmd[5:4];
                            k_q      <= cmd[3:2];
                            col      <= '0;
                            is_vec   <= (op == 4'd2);
                            is_ident <= (op == 4'd4);
                            case (op)
                                4'd1, 4'd2: state <= S_RD;
                                4'd3, 4'd4: state <= S_FILL;
                                default:    state <= S_IDLE;
                            endcase
                        end
                    end
                end
                S_RD: begin
                    result <= mul_out;
                    state  <= S_WR;
                end
                S_WR: begin
                    if (is_vec || col == 2'd3) begin
                        state <= S_IDLE;
                    end else begin
                        col   <= col + 2'd1;
                        state <= S_RD;
                    end
                end
                S_FILL: begin
                    if (col == 2'd3) state <= S_IDLE;
                    else col <= col + 2'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rf_rd_mat_idx     = '0;
        rf_rd_vector_type = '0;
        rf_rd_vector_idx  = '0;
        rf_we             = 1'b0;
        rf_wr_mat_idx     = '0;
        rf_wr_vector_type = '0;
        rf_wr_vector_idx  = '0;
        rf_wr_vals        = '0;
        mul_mat_idx       = '0;
        case (phase)
            S_HOST: begin
                if (we) begin
                    rf_we             = 1'b1;
                    rf_wr_mat_idx     = dat_mat_idx;
                    rf_wr_vector_type = dat_vector_type;
                    rf_wr_vector_idx  = dat_vector_idx;
                    rf_wr_vals        = dat_in;
                end else begin
                    rf_rd_mat_idx     = dat_mat_idx;
                    rf_rd_vector_type = dat_vector_type;
                    rf_rd_vector_idx  = dat_vector_idx;
                end
            end
            S_RD: begin
                rf_rd_mat_idx    = b_q;
                rf_rd_vector_idx = is_vec ? j_q : col;
                mul_mat_idx      = a_q;
            end
            S_WR: begin
                rf_we            = 1'b1;
                rf_wr_mat_idx    = d_q;
                rf_wr_vector_idx = is_vec ? k_q : col;
                rf_wr_vals       = result;
            end
            S_FILL: begin
                rf_we            = 1'b1;
                rf_wr_mat_idx    = d_q;
                rf_wr_vector_idx = col;
                rf_wr_vals       = is_ident ? (64'h1000 << {col, 4'b0}) : '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gpu_mat_seq.sv
// Bench for gpu_mat_seq: behavioural register file behind the DUT plus a matrix-level reference.
module tb_gpu_mat_seq;

    typedef logic [15:0] mat_t [4][4];

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  dat_mat_idx, dat_vector_type, dat_vector_idx;
    logic [63:0] dat_in, dat_out;
    logic        cyc, we, ack;
    logic [15:0] cmd;
    logic        cmd_valid, cmd_ready, busy, cmd_err;
    logic [1:0]  rf_rd_mat_idx, rf_rd_vector_type, rf_rd_vector_idx;
    logic [63:0] rf_rd_vals;
    logic        rf_we;
    logic [1:0]  rf_wr_mat_idx, rf_wr_vector_type, rf_wr_vector_idx;
    logic [63:0] rf_wr_vals;
    logic [1:0]  mul_mat_idx;
    logic [63:0] mul_in, mul_out;

    logic        cmd_valid3, cmd_ready3, busy3, cmd_err3, ack3, rf_we3;
    logic [63:0] dat_out3, rf_wr_vals3, mul_in3;
    logic [1:0]  rd_mat3, rd_type3, rd_idx3, wr_mat3, wr_type3, wr_idx3, mul_mat3;

    mat_t        rf [4];
    mat_t        refm [4];
    int          checks = 0;
    int          failures = 0;
    logic [63:0] last_rd;

    always #5 clk = ~clk;

    gpu_mat_seq #(.MAT_COUNT(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .dat_mat_idx(dat_mat_idx), .dat_vector_type(dat_vector_type), .dat_vector_idx(dat_vector_idx),
        .dat_in(dat_in), .dat_out(dat_out), .cyc(cyc), .we(we), .ack(ack),
        .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .busy(busy), .cmd_err(cmd_err),
        .rf_rd_mat_idx(rf_rd_mat_idx), .rf_rd_vector_type(rf_rd_vector_type), .rf_rd_vector_idx(rf_rd_vector_idx),
        .rf_rd_vals(rf_rd_vals), .rf_we(rf_we),
        .rf_wr_mat_idx(rf_wr_mat_idx), .rf_wr_vector_type(rf_wr_vector_type), .rf_wr_vector_idx(rf_wr_vector_idx),
        .rf_wr_vals(rf_wr_vals), .mul_mat_idx(mul_mat_idx), .mul_in(mul_in), .mul_out(mul_out)
    );

    gpu_mat_seq #(.MAT_COUNT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .dat_mat_idx(2'd0), .dat_vector_type(2'd0), .dat_vector_idx(2'd0),
        .dat_in(64'd0), .dat_out(dat_out3), .cyc(1'b0), .we(1'b0), .ack(ack3),
        .cmd(cmd), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .busy(busy3), .cmd_err(cmd_err3),
        .rf_rd_mat_idx(rd_mat3), .rf_rd_vector_type(rd_type3), .rf_rd_vector_idx(rd_idx3),
        .rf_rd_vals(64'd0), .rf_we(rf_we3),
        .rf_wr_mat_idx(wr_mat3), .rf_wr_vector_type(wr_type3), .rf_wr_vector_idx(wr_idx3),
        .rf_wr_vals(rf_wr_vals3), .mul_mat_idx(mul_mat3), .mul_in(mul_in3), .mul_out(64'd0)
    );

    // Vector element i of (type, idx) lives at row r, col c.
    function automatic void pos(input logic [1:0] t, input logic [1:0] idx, input int i, output int r, output int c);
        case (t)
            2'd0:    begin r = i;        c = int'(idx); end
            2'd1:    begin r = int'(idx); c = i;       end
            2'd2:    begin r = i;        c = i;        end
            default: begin r = i;        c = 3 - i;    end
        endcase
    endfunction

    function automatic logic [63:0] get_vec(input mat_t m, input logic [1:0] t, input logic [1:0] idx);
        logic [63:0] v;
        int r, c;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            pos(t, idx, i, r, c);
            v[16*i +: 16] = m[r][c];
        end
        return v;
    endfunction

    function automatic logic [63:0] mvmul(input mat_t m, input logic [63:0] v);
        logic [63:0] o;
        logic signed [31:0] acc, p;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int c = 0; c < 4; c++) begin
                p = $signed(m[r][c]) * $signed(v[16*c +: 16]);
                acc = acc + (p >>> 12);
            end
            o[16*r +: 16] = acc[15:0];
        end
        return o;
    endfunction

    assign rf_rd_vals = get_vec(rf[rf_rd_mat_idx], rf_rd_vector_type, rf_rd_vector_idx);
    assign mul_out    = mvmul(rf[mul_mat_idx], rf_rd_vals);

    always @(posedge clk) begin : rf_model
        int r, c;
        if (rf_we) begin
            for (int i = 0; i < 4; i++) begin
                pos(rf_wr_vector_type, rf_wr_vector_idx, i, r, c);
                rf[rf_wr_mat_idx][r][c] <= rf_wr_vals[16*i +: 16];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] d, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] j, input logic [1:0] k);
        return {op, d, a, b, j, k, 2'b00};
    endfunction

    function automatic logic illegal(input logic [15:0] cm, input int mc);
        int op, d, a, b;
        op = int'(cm[15:12]); d = int'(cm[11:10]); a = int'(cm[9:8]); b = int'(cm[7:6]);
        if (op > 4) return 1'b1;
        if (op == 1 || op == 2) return (d >= mc) || (a >= mc) || (b >= mc) || (d == a);
        if (op == 3 || op == 4) return d >= mc;
        return 1'b0;
    endfunction

    task automatic ref_write(input logic [1:0] m, input logic [1:0] t, input logic [1:0] idx, input logic [63:0] v);
        int r, c;
        for (int i = 0; i < 4; i++) begin
            pos(t, idx, i, r, c);
            refm[m][r][c] = v[16*i +: 16];
        end
    endtask

    // Apply a legal command to the reference, limited to its first ncols columns.
    task automatic ref_cmd(input logic [15:0] cm, input int ncols);
        logic [1:0] d, a, b, j, k;
        d = cm[11:10]; a = cm[9:8]; b = cm[7:6]; j = cm[5:4]; k = cm[3:2];
        case (cm[15:12])
            4'd1: for (int c = 0; c < ncols; c++)
                      ref_write(d, 2'd0, 2'(c), mvmul(refm[a], get_vec(refm[b], 2'd0, 2'(c))));
            4'd2: ref_write(d, 2'd0, k, mvmul(refm[a], get_vec(refm[b], 2'd0, j)));
            4'd3: for (int c = 0; c < 4; c++) ref_write(d, 2'd0, 2'(c), 64'd0);
            4'd4: for (int c = 0; c < 4; c++) ref_write(d, 2'd0, 2'(c), 64'h1000 << (16*c));
            default: ;
        endcase
    endtask

    task automatic host(input logic w, input logic [1:0] m, input logic [1:0] t, input logic [1:0] idx,
                        input logic [63:0] data);
        int lat;
        logic [63:0] exp_v;
        exp_v = get_vec(refm[m], t, idx);
        @(posedge clk); #1;
        cyc = 1'b1; we = w; dat_mat_idx = m; dat_vector_type = t; dat_vector_idx = idx; dat_in = data;
        lat = -1;
        for (int n = 0; n < 30 && lat < 0; n++) begin
            @(negedge clk);
            if (ack) lat = n;
        end
        cyc = 1'b0;
        check("host_ack_lat", 64'(lat), 64'd1);
        if (w) ref_write(m, t, idx, data);
        else begin
            check("host_rd", dat_out, exp_v);
            last_rd = exp_v;
        end
    endtask

    task automatic run_cmd(input logic [15:0] cm);
        logic [9:0] bm, wm, em, eb, ew, ee;
        int n;
        @(posedge clk); #1;
        cmd = cm; cmd_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 20);
        check("cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bm[i] = busy; wm[i] = rf_we; em[i] = cmd_err;
        end
        eb = '0; ew = '0; ee = '0;
        if (illegal(cm, 4)) ee = 10'h001;
        else begin
            case (cm[15:12])
                4'd1:       begin eb = 10'h0FF; ew = 10'h0AA; end
                4'd2:       begin eb = 10'h003; ew = 10'h002; end
                4'd3, 4'd4: begin eb = 10'h00F; ew = 10'h00F; end
                default: ;
            endcase
            ref_cmd(cm, 4);
        end
        check("busy_seq", 64'(bm), 64'(eb));
        check("we_seq", 64'(wm), 64'(ew));
        check("err_seq", 64'(em), 64'(ee));
        check("idle_outs", {rf_rd_mat_idx, rf_rd_vector_type, rf_rd_vector_idx, rf_wr_mat_idx,
                            rf_wr_vector_type, rf_wr_vector_idx, mul_mat_idx, cmd_ready}, 64'd1);
        check("idle_wr_vals", rf_wr_vals, 64'd0);
    endtask

    task automatic dut3_cmd(input logic [15:0] cm, input logic [5:0] ee, input logic [5:0] ew);
        logic [5:0] em, wm;
        @(posedge clk); #1;
        cmd = cm; cmd_valid3 = 1'b1;
        @(negedge clk);
        check("d3_ready", 64'(cmd_ready3), 64'd1);
        @(posedge clk); #1;
        cmd_valid3 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            em[i] = cmd_err3; wm[i] = rf_we3;
        end
        check("d3_err_seq", 64'(em), 64'(ee));
        check("d3_we_seq", 64'(wm), 64'(ew));
    endtask

    task automatic verify_all();
        for (int m = 0; m < 4; m++)
            for (int c = 0; c < 4; c++)
                host(1'b0, 2'(m), 2'd0, 2'(c), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cm;
        logic [63:0] rd, exp_v;
        int n, ack_n, busy_n, sel;
        logic [3:0] op;

        rst_n = 1'b0; cyc = 1'b0; we = 1'b0; dat_mat_idx = '0; dat_vector_type = '0;
        dat_vector_idx = '0; dat_in = '0; cmd = '0; cmd_valid = 1'b0; cmd_valid3 = 1'b0; last_rd = '0;
        for (int m = 0; m < 4; m++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) refm[m][r][c] = '0;

        repeat (2) @(negedge clk);
        check("rst_dat_out", dat_out, 64'd0);
        check("rst_ctrl", {ack, cmd_ready, busy, cmd_err, rf_we}, 64'b01000);
        check("rst_addr", {rf_rd_mat_idx, rf_rd_vector_type, rf_rd_vector_idx, rf_wr_mat_idx,
                           rf_wr_vector_type, rf_wr_vector_idx, mul_mat_idx}, 64'd0);
        check("rst_wr_vals", rf_wr_vals, 64'd0);
        rst_n = 1'b1;

        for (int m = 0; m < 4; m++) run_cmd(mk(4'd3, 2'(m), 2'd0, 2'd0, 2'd0, 2'd0));

        // Back-to-back host write then read, cyc held across the ack.
        @(posedge clk); #1;
        cyc = 1'b1; we = 1'b1; dat_mat_idx = 2'd1; dat_vector_type = 2'd1; dat_vector_idx = 2'd2;
        dat_in = 64'h4000_3000_2000_1000;
        @(negedge clk);
        check("b2b_ack_h", 64'(ack), 64'd0);
        @(negedge clk);
        check("b2b_ack_h1", 64'(ack), 64'd1);
        ref_write(2'd1, 2'd1, 2'd2, 64'h4000_3000_2000_1000);
        we = 1'b0;
        @(negedge clk);
        check("b2b_ack_pulse", 64'(ack), 64'd0);
        @(negedge clk);
        check("b2b_ack_h3", 64'(ack), 64'd1);
        check("b2b_rd", dat_out, 64'h4000_3000_2000_1000);
        cyc = 1'b0;
        @(negedge clk);
        check("ack_drop", 64'(ack), 64'd0);

        run_cmd(mk(4'd4, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
        for (int r = 0; r < 4; r++) host(1'b1, 2'd1, 2'd1, 2'(r), {$urandom, $urandom});
        run_cmd(mk(4'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0));
        for (int c = 0; c < 4; c++) begin
            exp_v = get_vec(refm[1], 2'd0, 2'(c));
            host(1'b0, 2'd2, 2'd0, 2'(c), 64'd0);
            check("ident_matmul", last_rd, exp_v);
        end

        run_cmd(mk(4'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd0));
        exp_v = get_vec(refm[1], 2'd0, 2'd2);
        host(1'b0, 2'd3, 2'd0, 2'd0, 64'd0);
        check("matvec_col", last_rd, exp_v);

        run_cmd(mk(4'hF, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0));
        run_cmd(mk(4'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0));
        run_cmd(mk(4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
        dut3_cmd(mk(4'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0), 6'h01, 6'h00);
        dut3_cmd(mk(4'd1, 2'd0, 2'd3, 2'd1, 2'd0, 2'd0), 6'h01, 6'h00);
        dut3_cmd(mk(4'd3, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0), 6'h00, 6'h0F);

        // Host request raised while a MATMUL is running.
        cm = mk(4'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0);
        @(posedge clk); #1;
        cmd = cm; cmd_valid = 1'b1;
        @(negedge clk);
        check("mm_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cyc = 1'b1; we = 1'b0;
        dat_mat_idx = 2'd2; dat_vector_type = 2'd0; dat_vector_idx = 2'd3;
        ref_cmd(cm, 4);
        n = 0; ack_n = -1;
        while (ack_n < 0 && n < 30) begin
            @(negedge clk); n++;
            if (ack) ack_n = n;
        end
        cyc = 1'b0;
        check("ack_after_cmd", 64'(ack_n), 64'd10);
        check("rd_after_cmd", dat_out, get_vec(refm[2], 2'd0, 2'd3));

        // cmd_valid and cyc in the same IDLE cycle.
        cm = mk(4'd4, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0);
        exp_v = get_vec(refm[3], 2'd0, 2'd1);
        @(posedge clk); #1;
        cmd = cm; cmd_valid = 1'b1; cyc = 1'b1; we = 1'b0;
        dat_mat_idx = 2'd3; dat_vector_type = 2'd0; dat_vector_idx = 2'd1;
        ack_n = -1; busy_n = -1; rd = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) check("ready_vs_cyc", 64'(cmd_ready), 64'd0);
            if (ack && ack_n < 0) begin ack_n = i; rd = dat_out; cyc = 1'b0; end
            if (busy && busy_n < 0) begin busy_n = i; cmd_valid = 1'b0; end
        end
        cmd_valid = 1'b0;
        check("host_first_ack", 64'(ack_n), 64'd1);
        check("cmd_after_ack", 64'(busy_n), 64'd3);
        check("host_first_rd", rd, exp_v);
        ref_cmd(cm, 4);

        // Reset during MATMUL, just before the second column write.
        cm = mk(4'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd0);
        @(posedge clk); #1;
        cmd = cm; cmd_valid = 1'b1;
        @(negedge clk);
        check("mr_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("we_before_rst", 64'(rf_we), 64'd1);
        rst_n = 1'b0;
        #1;
        check("we_in_rst", {rf_we, busy}, 64'd0);
        ref_cmd(cm, 1);
        @(negedge clk);
        rst_n = 1'b1;
        last_rd = '0;
        for (int c = 0; c < 4; c++) host(1'b0, 2'd2, 2'd0, 2'(c), 64'd0);

        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3) begin
                host(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     {$urandom, $urandom});
            end else if (sel < 5) begin
                host(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 64'd0);
            end else begin
                n = $urandom_range(0, 7);
                if (n < 5) op = 4'(n);
                else if (n == 5) op = 4'($urandom_range(5, 15));
                else op = 4'($urandom_range(1, 2));
                run_cmd(mk(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))));
            end
            check("dat_out_hold", dat_out, last_rd);
        end

        verify_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
